div8by4_seq: RTL and testbench

//  Sequential restoring divider; the inverse of the team's shift-add multiplier.

---
 rtl/seqarith_pkg.sv | 33 +++
 rtl/div_cond_sub.sv | 34 +++
 rtl/div8by4_seq.sv | 157 +++++++++++++++
 tb/tb_div8by4_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seqarith_pkg.sv
// ---------------------------------------------------------------------------
// seqarith_pkg
// Shared definitions for the sequential arithmetic units (shift-add
// multiplier and restoring divider).
//   DW_DEF / DVW_DEF : default dividend/quotient and divisor/remainder widths
//   clog2()          : ceiling log2, used to size iteration counters
//   state_t          : common IDLE / RUN / FIN control states
// ---------------------------------------------------------------------------
package seqarith_pkg;

    localparam int DW_DEF  = 8;
    localparam int DVW_DEF = 4;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_cond_sub.sv
// ---------------------------------------------------------------------------
// div_cond_sub
// Combinational (DVW+1)-bit compare-and-subtract stage of the restoring
// divider. This is the only subtractor in the divider.
// Ports:
//   partial  in  DVW+1  shifted remainder candidate {rem_acc, next dividend bit}
//   divisor  in  DVW    divisor
//   ge       out 1      partial >= divisor (quotient bit for this step)
//   diff     out DVW    partial - divisor; meaningful only when ge is set
// ---------------------------------------------------------------------------
module div_cond_sub
    import seqarith_pkg::*;
#(
    parameter int DVW = DVW_DEF
) (
    input  logic [DVW:0]   partial,
    input  logic [DVW-1:0] divisor,
    output logic           ge,
    output logic [DVW-1:0] diff
);

    logic [DVW:0] divisor_ext;
    logic [DVW:0] full_diff;

    // When ge is set the difference is below the divisor, so the top bit of
    // the full-width result is always zero and can be dropped.
    always_comb begin
        divisor_ext = {1'b0, divisor};
        full_diff   = partial - divisor_ext;
        ge          = (partial >= divisor_ext);
        diff        = full_diff[DVW-1:0];
    end

endmodule

// File: rtl/div8by4_seq.sv
// ---------------------------------------------------------------------------
// div8by4_seq
// Sequential restoring divider: unsigned DW-bit dividend / DVW-bit divisor,
// one quotient bit per clock, start/done handshake matching the sequential
// multiplier.
// Ports:
//   clk          in   1    clock, rising edge
//   rst          in   1    asynchronous active-high reset
//   start        in   1    request, accepted when busy==0
//   dividend     in   DW   sampled on an accepted start
//   divisor      in   DVW  sampled on an accepted start
//   quotient     out  DW   result, valid while done==1
//   remainder    out  DVW  result, valid while done==1
//   busy         out  1    iteration in progress
//   done         out  1    result held, until the next accepted start
//   div_by_zero  out  1    divisor was zero, same lifetime as done
// ---------------------------------------------------------------------------
module div8by4_seq
    import seqarith_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int DVW = DVW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DW-1:0]  dividend,
    input  logic [DVW-1:0] divisor,
    output logic [DW-1:0]  quotient,
    output logic [DVW-1:0] remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    localparam int            CW       = clog2(DW + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    state_t         state_q, state_d;
    logic           zero_pend_q, zero_pend_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DW-1:0]  dvd_sh_q, dvd_sh_d;
    logic [DW-1:0]  quo_sh_q, quo_sh_d;
    logic [DVW-1:0] divisor_q, divisor_d;
    logic [DVW-1:0] rem_acc_q, rem_acc_d;
    logic [DW-1:0]  quotient_q, quotient_d;
    logic [DVW-1:0] remainder_q, remainder_d;
    logic           div_by_zero_q, div_by_zero_d;

    logic [DVW:0]   partial;
    logic           sub_ge;
    logic [DVW-1:0] sub_diff;

    assign partial = {rem_acc_q, dvd_sh_q[DW-1]};

    div_cond_sub #(
        .DVW(DVW)
    ) u_cond_sub (
        .partial (partial),
        .divisor (divisor_q),
        .ge      (sub_ge),
        .diff    (sub_diff)
    );

    // Next-state logic. RUN performs one restoring step per edge; the
    // quotient/remainder outputs stay cleared until the last step so that
    // partial results are never visible. A zero divisor skips RUN entirely:
    // zero_pend holds the request for one edge and then lands in FIN with
    // the saturated quotient. Outside RUN a start is always accepted, which
    // also covers restarting straight from FIN.
    always_comb begin
        state_d       = state_q;
        zero_pend_d   = zero_pend_q;
        count_d       = count_q;
        dvd_sh_d      = dvd_sh_q;
        quo_sh_d      = quo_sh_q;
        divisor_d     = divisor_q;
        rem_acc_d     = rem_acc_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            RUN: begin
                dvd_sh_d  = {dvd_sh_q[DW-2:0], 1'b0};
                quo_sh_d  = {quo_sh_q[DW-2:0], sub_ge};
                rem_acc_d = sub_ge ? sub_diff : partial[DVW-1:0];
                count_d   = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    state_d     = FIN;
                    quotient_d  = quo_sh_d;
                    remainder_d = rem_acc_d;
                end
            end
            default: begin
                if (zero_pend_q) begin
                    state_d       = FIN;
                    zero_pend_d   = 1'b0;
                    div_by_zero_d = 1'b1;
                    quotient_d    = '1;
                    remainder_d   = '0;
                end
                if (start) begin
                    dvd_sh_d      = dividend;
                    divisor_d     = divisor;
                    quo_sh_d      = '0;
                    rem_acc_d     = '0;
                    count_d       = '0;
                    quotient_d    = '0;
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = IDLE;
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        zero_pend_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            zero_pend_q   <= 1'b0;
            count_q       <= '0;
            dvd_sh_q      <= '0;
            quo_sh_q      <= '0;
            divisor_q     <= '0;
            rem_acc_q     <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            zero_pend_q   <= zero_pend_d;
            count_q       <= count_d;
            dvd_sh_q      <= dvd_sh_d;
            quo_sh_q      <= quo_sh_d;
            divisor_q     <= divisor_d;
            rem_acc_q     <= rem_acc_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// ---------------------------------------------------------------------------
// tb_div8by4_seq
// Directed self-checking bench for div8by4_seq plus an exhaustive operand
// sweep checked against the division identity.
// ---------------------------------------------------------------------------
module tb_div8by4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks_total;
    int checks_passed;

    div8by4_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns 1ns after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        step();
        step();
        checks_total++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0)
            $display("[TB] FAIL reset_outputs got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        else checks_passed++;
        rst = 1'b0;
        step();
        checks_total++;
        if ({busy, done} !== 2'b00)
            $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        else checks_passed++;
    endtask

    // Runs one normal division and checks busy/done timing and result.
    task automatic run_normal(input string name, input logic [7:0] a, input logic [3:0] b,
                              input logic [7:0] exp_q, input logic [3:0] exp_r);
        bit timing_ok;
        issue(a, b);
        checks_total++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd0)
            $display("[TB] FAIL %s_accept got busy=%b done=%b q=%0d want 1 0 0", name, busy, done, quotient);
        else checks_passed++;
        timing_ok = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd0)
                timing_ok = 1'b0;
        end
        checks_total++;
        if (!timing_ok)
            $display("[TB] FAIL %s_busy_window got early done/clear violation want busy for 8 cycles", name);
        else checks_passed++;
        step();
        checks_total++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== exp_q || remainder !== exp_r || div_by_zero !== 1'b0)
            $display("[TB] FAIL %s_result got done=%b busy=%b q=%0d r=%0d dz=%b want 1 0 q=%0d r=%0d dz=0",
                     name, done, busy, quotient, remainder, div_by_zero, exp_q, exp_r);
        else checks_passed++;
    endtask

    task automatic test_basic();
        run_normal("div_100_7", 8'd100, 4'd7, 8'd14, 4'd2);
    endtask

    task automatic test_patterns();
        run_normal("div_255_15", 8'd255, 4'd15, 8'd17, 4'd0);
        run_normal("div_5_9", 8'd5, 4'd9, 8'd0, 4'd5);
        run_normal("div_0_3", 8'd0, 4'd3, 8'd0, 4'd0);
    endtask

    task automatic test_div_zero();
        issue(8'd42, 4'd0);
        checks_total++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0)
            $display("[TB] FAIL dz_accept got busy=%b done=%b dz=%b want 0 0 0", busy, done, div_by_zero);
        else checks_passed++;
        step();
        checks_total++;
        if (done !== 1'b1 || div_by_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 4'd0 || busy !== 1'b0)
            $display("[TB] FAIL dz_result got done=%b dz=%b q=%0d r=%0d busy=%b want 1 1 255 0 0",
                     done, div_by_zero, quotient, remainder, busy);
        else checks_passed++;
        step();
        checks_total++;
        if (done !== 1'b1 || div_by_zero !== 1'b1)
            $display("[TB] FAIL dz_hold got done=%b dz=%b want 1 1", done, div_by_zero);
        else checks_passed++;
    endtask

    task automatic test_start_ignored();
        issue(8'd200, 4'd3);
        step();
        step();
        dividend = 8'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checks_total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL ignored_start_busy got busy=%b done=%b want 1 0", busy, done);
        else checks_passed++;
        for (int i = 4; i < 8; i++) step();
        step();
        checks_total++;
        if (done !== 1'b1 || quotient !== 8'd66 || remainder !== 4'd2)
            $display("[TB] FAIL ignored_start_result got done=%b q=%0d r=%0d want 1 66 2", done, quotient, remainder);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        issue(8'd77, 4'd5);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checks_total++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0)
            $display("[TB] FAIL mid_reset got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        else checks_passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL no_done_after_reset got done=%b busy=%b want 0 0", done, busy);
        else checks_passed++;
        run_normal("div_77_5", 8'd77, 4'd5, 8'd15, 4'd2);
    endtask

    task automatic test_back_to_back();
        run_normal("div_9_4_first", 8'd9, 4'd4, 8'd2, 4'd1);
        run_normal("div_9_4_b2b", 8'd9, 4'd4, 8'd2, 4'd1);
    endtask

    task automatic test_sweep();
        int sweep_fail;
        int waited;
        int exp_q;
        int exp_r;
        sweep_fail = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(8'(a), 4'(b));
                waited = 0;
                while (done !== 1'b1 && waited < 12) begin
                    step();
                    waited++;
                end
                if (b == 0) begin
                    exp_q = 255;
                    exp_r = 0;
                end else begin
                    exp_q = a / b;
                    exp_r = a % b;
                end
                checks_total++;
                if (done !== 1'b1 || int'(quotient) != exp_q || int'(remainder) != exp_r ||
                    div_by_zero !== (b == 0) ||
                    (b != 0 && (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b))) begin
                    sweep_fail++;
                    if (sweep_fail <= 5)
                        $display("[TB] FAIL sweep_%0d_%0d got done=%b q=%0d r=%0d dz=%b want q=%0d r=%0d",
                                 a, b, done, quotient, remainder, div_by_zero, exp_q, exp_r);
                end else checks_passed++;
            end
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
